// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) arithmetic for the decryption datapath.
package aes_pkg;

  localparam logic [7:0] AES_POLY_RED = 8'h1B;

  // First row of the InvMixColumns circulant matrix; row r is this rotated right by r.
  localparam logic [7:0] INV_MC_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  typedef logic [31:0]  column_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] coef);
    logic [7:0] acc;
    logic [7:0] a;
    acc = '0;
    a   = b;
    for (int i = 0; i < 8; i++) begin
      if (coef[i]) acc = acc ^ a;
      a = xtime(a);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumn of one 32-bit column (byte [31:24] = row 0).
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a [4];
  logic [7:0] b [4];

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      a[j] = col_in[31-8*j -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      b[r] = '0;
      for (int j = 0; j < 4; j++) begin
        b[r] = b[r] ^ gf_mul(a[j], INV_MC_COEF[2'(j - r)]);
      end
    end
  end

  assign col_out = {b[0], b[1], b[2], b[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential inverse MixColumns: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  fsm_t       state_q;
  fsm_t       state_d;
  logic [1:0] cnt_q;
  state_t     work_q;
  state_t     work_nxt;
  state_t     out_q;
  logic       out_vld_q;
  logic       accept;
  logic       last_step;

  column_t    cols     [4];
  column_t    cols_nxt [4];
  column_t    mix_in   [COLS_PER_CYCLE];
  column_t    mix_out  [COLS_PER_CYCLE];
  logic [1:0] col_idx  [COLS_PER_CYCLE];

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);
  assign out_valid = out_vld_q;
  assign state_out = out_q;

  for (genvar j = 0; j < 4; j++) begin : g_unpack
    assign cols[j] = work_q[127-32*j -: 32];
  end

  // Column slice selected by the counter, transformed in place
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    assign col_idx[k] = cnt_q + 2'(k);
    assign mix_in[k]  = cols[col_idx[k]];
    inv_mix_column u_imc (
      .col_in  (mix_in[k]),
      .col_out (mix_out[k])
    );
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      cols_nxt[j] = cols[j];
    end
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      cols_nxt[col_idx[k]] = mix_out[k];
    end
  end

  assign work_nxt = {cols_nxt[0], cols_nxt[1], cols_nxt[2], cols_nxt[3]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The final column write also publishes the whole state, so DONE always has out_valid set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DONE && out_ready) begin
        out_vld_q <= 1'b0;
      end
      if (accept) begin
        work_q <= state_in;
        cnt_q  <= '0;
      end else if (state_q == ST_BUSY) begin
        work_q <= work_nxt;
        cnt_q  <= cnt_q + STEP;
        if (last_step) begin
          out_q     <= work_nxt;
          out_vld_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] state_in;
  logic [127:0] state_out [3];

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .state_out(state_out[0]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .state_out(state_out[1]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .state_in(state_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .state_out(state_out[2]));

  typedef struct {
    logic [127:0] exp;
    logic [127:0] inp;
    int           acc;
  } item_t;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    sel = 0;
  int    lat [3] = '{5, 3, 2};
  logic  tp_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (dut %0d): got %h expected %h", name, sel, act, req);
    end
  endtask

  // Independent forward MixColumns; since MC^4 = I, the inverse is MC^3.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] s);
    return fwd_state(fwd_state(fwd_state(s)));
  endfunction

  // Monitor: samples 2 time units after the falling edge, when the drivers are settled
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic [127:0] prev_d = '0;
  int           rise_cyc = 0;
  int           last_hs = -1;
  item_t        it;

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (prev_v && !prev_r) begin
        check("hold_valid", 128'(out_valid[sel]), 128'(1));
        check("hold_data", state_out[sel], prev_d);
      end
      if (out_valid[sel] && !prev_v) rise_cyc = cyc;
      if (out_valid[sel] && out_ready[sel]) begin
        if (sb.size() == 0) begin
          check("spurious_output", 128'(out_valid[sel]), 128'(0));
        end else begin
          it = sb.pop_front();
          check("data", state_out[sel], it.exp);
          check("latency", 128'(rise_cyc - it.acc), 128'(lat[sel]));
          check("fwd_roundtrip", fwd_state(state_out[sel]), it.inp);
          if (tp_on && last_hs >= 0) check("period", 128'(cyc - last_hs), 128'(lat[sel]));
          last_hs = cyc;
        end
      end
      prev_v = out_valid[sel];
      prev_r = out_ready[sel];
      prev_d = state_out[sel];
    end else begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting clock.
  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int n;
    state_in      = d;
    in_valid[sel] = 1'b1;
    #1;
    n = 0;
    while (!in_ready[sel] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready[sel]) begin
      check("accept_timeout", 128'(in_ready[sel]), 128'(1));
    end else begin
      sb.push_back('{exp: e, inp: d, acc: cyc});
    end
    @(negedge clk);
    in_valid[sel] = 1'b0;
    state_in      = 'x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  logic [127:0] dir_in  [4];
  logic [127:0] dir_exp [4];
  logic [127:0] strm    [8];
  logic [127:0] bp_a;
  int           n;

  initial begin
    dir_in[0]  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    dir_exp[0] = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    dir_in[1]  = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;
    dir_exp[1] = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;
    dir_in[2]  = 128'h0;
    dir_exp[2] = 128'h0;
    dir_in[3]  = 128'h4d7ebdf8_00000000_00000000_00000000;
    dir_exp[3] = 128'h2d26314c_00000000_00000000_00000000;
    strm[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    strm[1] = 128'h01234567_89abcdef_fedcba98_76543210;
    strm[2] = 128'hdeadbeef_cafebabe_0badf00d_feedface;
    strm[3] = 128'h13579bdf_2468ace0_f0e1d2c3_b4a59687;
    strm[4] = 128'hffffffff_00000000_80808080_7f7f7f7f;
    strm[5] = 128'ha5a5a5a5_5a5a5a5a_3c3c3c3c_c3c3c3c3;
    strm[6] = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    strm[7] = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 3'b111;
    state_in  = 'x;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      check("reset_out_valid", 128'(out_valid[i]), 128'(0));
      check("reset_state_out", state_out[i], 128'h0);
      check("reset_in_ready", 128'(in_ready[i]), 128'(1));
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors on every column width
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int v = 0; v < 4; v++) begin
        send(dir_in[v], dir_exp[v]);
        drain();
      end
    end

    // Backpressure with a second state waiting upstream
    sel  = 0;
    bp_a = dir_in[0];
    out_ready[0] = 1'b0;
    send(bp_a, dir_exp[0]);
    state_in    = dir_in[3];
    in_valid[0] = 1'b1;
    n = 0;
    #1;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bp_valid_rise", 128'(out_valid[0]), 128'(1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check("bp_in_ready_low", 128'(in_ready[0]), 128'(0));
      check("bp_state_held", state_out[0], dir_exp[0]);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    send(dir_in[3], dir_exp[3]);
    drain();

    // Back-to-back stream at four columns per cycle
    sel   = 2;
    tp_on = 1'b1;
    last_hs = -1;
    for (int v = 0; v < 8; v++) send(strm[v], inv_model(strm[v]));
    drain();
    tp_on = 1'b0;

    // Asynchronous reset in the second busy cycle
    sel = 0;
    send(dir_in[1], dir_exp[1]);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", 128'(out_valid[i]), 128'(0));
      check("rst_state_out", state_out[i], 128'h0);
      check("rst_in_ready", 128'(in_ready[i]), 128'(1));
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_stale_result", 128'(out_valid[0]), 128'(0));
    send(dir_in[0], dir_exp[0]);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
